// File: rtl/mac_pkg.sv
// Shared types and encodings for the MAC array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_LOAD_DRAIN = 3'd2,
    S_EXEC       = 3'd3,
    S_EXEC_DRAIN = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  // Array instruction encodings: [1] = execute, [0] = load
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_col_wr_cnt.sv
// Per-column count of returned output-valid pulses, saturating at the burst length.
// Latency: count updates 1 cycle after wr_i; err_o is combinational on the current pulse.
// Backpressure: none; every pulse is either counted or flagged.
module mac_col_wr_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             active_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             at_len_o,
  output logic             err_o
);

  logic [LEN_W-1:0] cnt_q;

  assign at_len_o = (cnt_q == len_i);
  // A pulse is bad if the sequencer is idle, the column is masked off, or the count is already full
  assign err_o    = wr_i && (!active_i || !en_i || at_len_o);

  // Count accepted pulses; cleared when a new operation starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (active_i && en_i && wr_i && !at_len_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mac_array_seq_ctrl.sv
// Sequencer issuing load/execute beats to a COL-wide MAC array and tracking returned results.
// Latency: outputs registered from next state; first beat on the cycle after start.
// Backpressure: ofifo_full=1 suppresses an execute beat on the following cycle without counting it.
module mac_array_seq_ctrl
  import mac_pkg::*;
#(
  parameter int COL   = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic [COL-1:0]   col_en,
  input  logic [COL-1:0]   fifo_wr,
  input  logic             ofifo_full,
  output logic [1:0]       inst,
  output logic [COL-1:0]   col_gate,
  output logic             busy,
  output logic             ld_done,
  output logic             exec_done,
  output logic             out_wr,
  output logic             err
);

  // One counter serves both beat issue (up to len) and drain (up to COL-1)
  localparam int CNT_W = (LEN_W > $clog2(COL) + 1) ? LEN_W : $clog2(COL) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [COL-1:0]   col_en_q, col_en_d;
  logic [1:0]       inst_q, inst_d;
  logic [COL-1:0]   col_gate_q;
  logic             busy_q, ld_done_q, exec_done_q, out_wr_q, err_q;
  logic             clr;
  logic             active;
  logic [COL-1:0]   at_len;
  logic [COL-1:0]   col_err;
  logic             all_done;
  logic [CNT_W-1:0] len_x;

  assign active   = (state_q != S_IDLE);
  assign len_x    = CNT_W'(len_q);
  assign all_done = &(at_len | ~col_en_q);

  for (genvar i = 0; i < COL; i++) begin : g_col
    mac_col_wr_cnt #(.LEN_W(LEN_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (clr),
      .active_i (active),
      .en_i     (col_en_q[i]),
      .wr_i     (fifo_wr[i]),
      .len_i    (len_q),
      .at_len_o (at_len[i]),
      .err_o    (col_err[i])
    );
  end

  // Next state, latches and the instruction for the coming cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    len_d    = len_q;
    col_en_d = col_en_q;
    inst_d   = INST_IDLE;
    clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          len_d    = len;
          col_en_d = col_en;
          clr      = 1'b1;
          cnt_d    = '0;
          if (mode) begin
            state_d = S_EXEC;
            if ((len != '0) && (col_en != '0) && !ofifo_full) begin
              inst_d = INST_EXEC;
              cnt_d  = CNT_W'(1);
            end
          end else begin
            state_d = S_LOAD;
            if (len != '0) begin
              inst_d = INST_LOAD;
              cnt_d  = CNT_W'(1);
            end
          end
        end
      end
      S_LOAD: begin
        if (len_q == '0) begin
          state_d = S_DONE;
        end else if (cnt_q == len_x) begin
          state_d = S_LOAD_DRAIN;
          cnt_d   = '0;
        end else begin
          inst_d = INST_LOAD;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_LOAD_DRAIN: begin
        if (cnt_q == CNT_W'(COL - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if ((len_q == '0) || (col_en_q == '0)) begin
          state_d = S_DONE;
        end else if (cnt_q == len_x) begin
          state_d = S_EXEC_DRAIN;
          cnt_d   = '0;
        end else if (!ofifo_full) begin
          inst_d = INST_EXEC;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_EXEC_DRAIN: begin
        if (all_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      col_en_q    <= '0;
      inst_q      <= INST_IDLE;
      col_gate_q  <= '0;
      busy_q      <= 1'b0;
      ld_done_q   <= 1'b0;
      exec_done_q <= 1'b0;
      out_wr_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      col_en_q    <= col_en_d;
      inst_q      <= inst_d;
      col_gate_q  <= (state_d != S_IDLE) ? col_en_d : '0;
      busy_q      <= (state_d != S_IDLE);
      ld_done_q   <= (state_d == S_DONE) && !mode_d;
      exec_done_q <= (state_d == S_DONE) && mode_d;
      out_wr_q    <= active && (col_en_q != '0) && ((fifo_wr & col_en_q) == col_en_q);
      err_q       <= err_q | (|col_err);
    end
  end

  assign inst      = inst_q;
  assign col_gate  = col_gate_q;
  assign busy      = busy_q;
  assign ld_done   = ld_done_q;
  assign exec_done = exec_done_q;
  assign out_wr    = out_wr_q;
  assign err       = err_q;

endmodule
